// File: rtl/aleatory_seq_pkg.sv
// ============================================================================
// Module : aleatory_seq_pkg
// Brief  : Shared types, sequence table and lookup helpers for the aleatory
//          0-4-1-6-5-2-3-7 counter stream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aleatory_seq_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Code emitted at each ordinal position of the stream.
  localparam logic [2:0] SEQ [0:7] = '{3'd0, 3'd4, 3'd1, 3'd6, 3'd5, 3'd2, 3'd3, 3'd7};

  function automatic logic [2:0] code2pos(input logic [2:0] code);
    logic [2:0] pos;
    pos = 3'd0;
    case (code)
      3'd0: pos = 3'd0;
      3'd4: pos = 3'd1;
      3'd1: pos = 3'd2;
      3'd6: pos = 3'd3;
      3'd5: pos = 3'd4;
      3'd2: pos = 3'd5;
      3'd3: pos = 3'd6;
      3'd7: pos = 3'd7;
      default: pos = 3'd0;
    endcase
    return pos;
  endfunction

  function automatic logic [2:0] next_code(input logic [2:0] code);
    logic [2:0] nxt_pos;
    nxt_pos = code2pos(code) + 3'd1;
    return SEQ[nxt_pos];
  endfunction

endpackage

`default_nettype wire

// File: rtl/aleatory_seq_decode.sv
// ============================================================================
// Module : aleatory_seq_decode
// Brief  : Combinational code-to-position and successor lookup.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aleatory_seq_decode
  import aleatory_seq_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] pos,
  output logic [2:0] succ
);

  assign pos  = code2pos(code);
  assign succ = next_code(code);

endmodule

`default_nettype wire

// File: rtl/aleatory_seq_checker.sv
// ============================================================================
// Module : aleatory_seq_checker
// Brief  : Receive-side lock/unlock checker for the aleatory counter stream.
//          Define SEQ_CHK_ERRCNT_EN to implement the saturating err_count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aleatory_seq_checker
  import aleatory_seq_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [2:0]       code_in,
  output logic [2:0]       pos_out,
  output logic             pos_valid,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_good_cnt, w_good_nxt;
  logic [3:0] r_bad_cnt, w_bad_nxt;
  logic [2:0] r_prev;
  logic       r_prev_valid;
  logic       w_mm_nxt;
  logic [2:0] w_in_pos;
  logic [2:0] w_prev_succ;
  logic [2:0] w_unused_pos;
  logic [2:0] w_unused_succ;
  logic       w_match;
  logic [3:0] w_good_inc;
  logic [3:0] w_bad_inc;

  aleatory_seq_decode u_dec_in (
    .code (code_in),
    .pos  (w_in_pos),
    .succ (w_unused_succ)
  );

  aleatory_seq_decode u_dec_prev (
    .code (r_prev),
    .pos  (w_unused_pos),
    .succ (w_prev_succ)
  );

  assign w_match    = (code_in == w_prev_succ);
  assign w_good_inc = r_good_cnt + 4'd1;
  assign w_bad_inc  = r_bad_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_mm_nxt    = 1'b0;
    // The first sample after reset only seeds prev; nothing to compare against.
    if (sample_en && r_prev_valid) begin
      case (r_state)
        HUNT: begin
          if (w_match) begin
            if (w_good_inc == 4'(LOCK_CNT)) begin
              w_state_nxt = LOCKED;
              w_good_nxt  = 4'd0;
              w_bad_nxt   = 4'd0;
            end else begin
              w_good_nxt = w_good_inc;
            end
          end else begin
            w_good_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_bad_nxt = 4'd0;
          end else begin
            w_mm_nxt = 1'b1;
            if (w_bad_inc == 4'(UNLOCK_CNT)) begin
              w_state_nxt = HUNT;
              w_good_nxt  = 4'd0;
              w_bad_nxt   = 4'd0;
            end else begin
              w_bad_nxt = w_bad_inc;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HUNT;
      r_good_cnt   <= 4'd0;
      r_bad_cnt    <= 4'd0;
      r_prev       <= 3'd0;
      r_prev_valid <= 1'b0;
      pos_out      <= 3'd0;
      pos_valid    <= 1'b0;
      mismatch     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
      pos_valid  <= sample_en;
      mismatch   <= w_mm_nxt;
      if (sample_en) begin
        r_prev       <= code_in;
        r_prev_valid <= 1'b1;
        pos_out      <= w_in_pos;
      end
    end
  end

  assign locked = (r_state == LOCKED);

`ifdef SEQ_CHK_ERRCNT_EN
  logic [ERR_W-1:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_mm_nxt && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

endmodule

`default_nettype wire
